// File: rtl/tqvp_vga_capture.sv
// TinyQV VGA line-capture peripheral: locks onto hsync/vsync and grabs 64 pixels of one scanline.
// Define VGACAP_MEASURE_EN to build the line-period / frame-height measurement and LOCK logic.
`timescale 1ns/1ps
module tqvp_vga_capture (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WAIT_LINE, S_SAMPLE} state_t;

    state_t      state;
    logic        hpol, vpol, vinv;
    logic [9:0]  target_y;
    logic [11:0] x_start;
    logic [6:0]  step;
    logic        done, ovr;
    logic [63:0] cap;
    logic [9:0]  line_cnt;
    logic        hs_prev, vs_prev;
    logic [13:0] x_cnt, nxt;
    logic [5:0]  pix;

    logic        wr_en, ctrl_wr;
    logic        hs_act, vs_act, hs_edge, vs_edge;
    logic        sample_now, busy;
    logic [11:0] line_period;
    logic [9:0]  frame_lines;
    logic        lock;

    assign wr_en      = (data_write_n != 2'b11);
    assign ctrl_wr    = wr_en && (address == 6'h00);
    assign hs_act     = ui_in[0] ^ hpol;
    assign vs_act     = ui_in[1] ^ vpol;
    assign hs_edge    = hs_act & ~hs_prev;
    assign vs_edge    = vs_act & ~vs_prev;
    assign sample_now = (state == S_SAMPLE) && (x_cnt == nxt);
    assign busy       = (state != S_IDLE);

    assign uo_out         = 8'd0;
    assign data_ready     = 1'b1;
    assign user_interrupt = done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            hpol     <= 1'b0;
            vpol     <= 1'b0;
            vinv     <= 1'b0;
            target_y <= '0;
            x_start  <= '0;
            step     <= '0;
            done     <= 1'b0;
            ovr      <= 1'b0;
            cap      <= '0;
            line_cnt <= '0;
            hs_prev  <= 1'b0;
            vs_prev  <= 1'b0;
            x_cnt    <= '0;
            nxt      <= '0;
            pix      <= '0;
        end else begin
            hs_prev <= hs_act;
            vs_prev <= vs_act;

            if (vs_edge)
                line_cnt <= '0;
            else if (hs_edge && line_cnt != 10'h3FF)
                line_cnt <= line_cnt + 10'd1;

            if (wr_en) begin
                case (address)
                    6'h04: target_y <= data_in[9:0];
                    6'h08: x_start  <= data_in[11:0];
                    6'h0C: step     <= data_in[6:0];
                    default: ;
                endcase
            end

            case (state)
                S_ARMED:
                    if (vs_edge) state <= S_WAIT_LINE;
                S_WAIT_LINE:
                    if (hs_edge && line_cnt == target_y) begin
                        state <= S_SAMPLE;
                        x_cnt <= '0;
                        nxt   <= {2'b00, x_start};
                        pix   <= '0;
                    end
                S_SAMPLE: begin
                    x_cnt <= x_cnt + 14'd1;
                    if (sample_now) begin
                        cap[pix] <= ui_in[2] ^ vinv;
                        pix      <= pix + 6'd1;
                        nxt      <= nxt + {7'd0, step} + 14'd1;
                    end
                    // A sync edge before the last pixel means the line ended early.
                    if (sample_now && pix == 6'd63) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else if (hs_edge || vs_edge) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                        ovr   <= 1'b1;
                    end
                end
                default: ;
            endcase

            // CTRL write overrides a same-cycle completion.
            if (ctrl_wr) begin
                hpol <= data_in[1];
                vpol <= data_in[2];
                vinv <= data_in[3];
                done <= 1'b0;
                ovr  <= 1'b0;
                if (data_in[0]) begin
                    cap   <= '0;
                    state <= S_ARMED;
                end
            end
        end
    end

`ifdef VGACAP_MEASURE_EN
    logic [11:0] per_cnt, lp_snap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per_cnt     <= '0;
            line_period <= '0;
            lp_snap     <= '0;
            frame_lines <= '0;
            lock        <= 1'b0;
        end else begin
            if (hs_edge) begin
                line_period <= per_cnt;
                per_cnt     <= 12'd1;
            end else if (per_cnt != 12'hFFF) begin
                per_cnt <= per_cnt + 12'd1;
            end
            // Lock requires this frame's geometry to equal the previous frame's.
            if (vs_edge) begin
                frame_lines <= line_cnt;
                lp_snap     <= line_period;
                lock        <= (line_cnt != 10'd0) && (line_cnt != 10'h3FF) &&
                               (line_period != 12'd0) && (line_period != 12'hFFF) &&
                               (line_cnt == frame_lines) && (line_period == lp_snap);
            end
        end
    end
`else
    assign line_period = '0;
    assign frame_lines = '0;
    assign lock        = 1'b0;
`endif

    always_comb begin
        data_out = 32'd0;
        case (address)
            6'h00: data_out = {28'd0, lock, ovr, done, busy};
            6'h04: data_out = {22'd0, target_y};
            6'h08: data_out = {20'd0, x_start};
            6'h0C: data_out = {25'd0, step};
            6'h10: data_out = {20'd0, line_period};
            6'h14: data_out = {22'd0, frame_lines};
            6'h18: data_out = cap[31:0];
            6'h1C: data_out = cap[63:32];
            default: data_out = 32'd0;
        endcase
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, data_read_n, ui_in[7:3], data_in[31:12]};

endmodule

// File: tb/tb_tqvp_vga_capture.sv
// Bench for tqvp_vga_capture: synthetic VGA timing with random video, checked against an arithmetic capture model.
`timescale 1ns/1ps
module tb_tqvp_vga_capture;
    localparam int P = 1344;
    localparam int L = 7;
    localparam int F = P * L;
    localparam int NV = 65536;
`ifdef VGACAP_MEASURE_EN
    localparam bit MEAS = 1'b1;
`else
    localparam bit MEAS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ui_in, uo_out;
    logic [5:0]  address;
    logic [31:0] data_in, data_out;
    logic [1:0]  data_write_n, data_read_n;
    logic        data_ready, user_interrupt;

    always #5 clk = ~clk;

    tqvp_vga_capture dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
        .address(address), .data_in(data_in), .data_write_n(data_write_n),
        .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
        .user_interrupt(user_interrupt)
    );

    int checks = 0;
    int errors = 0;
    int gt = 0;
    bit gen_on = 1'b0;
    bit vid [0:NV-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: hsync active for the first 8 clocks of each line, vsync active
    // for two lines starting mid-way through line 0; both pins active-low.
    task automatic tick();
        int x, pos;
        if (gen_on) begin
            x   = gt % P;
            pos = gt % F;
            ui_in = {5'd0, vid[gt], !((pos >= P/2) && (pos < P/2 + 2*P)), !(x < 8)};
        end else begin
            ui_in = 8'b0000_0011;
        end
        @(posedge clk);
        #1;
        if (gen_on) gt++;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        address = a; data_in = d; data_write_n = 2'b10;
        tick();
        data_write_n = 2'b11;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        address = a; data_read_n = 2'b10;
        #1;
        d = data_out;
        data_read_n = 2'b11;
    endtask

    task automatic chk_rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        chk(tag, v, exp);
    endtask

    task automatic run_to(input int t);
        while (gt < t) tick();
    endtask

    function automatic bit lock_exp();
        return MEAS && (gt - 1 >= 2*F + P/2);
    endfunction

    // Capture outcome from the timing rules: first vsync edge after the ARM
    // write, then the (ty+1)-th hsync edge, then pixel n at E+1+xs+n*(st+1).
    task automatic model(input int a, input int ty, input int xs, input int st, input bit inv,
                         output logic [63:0] bits, output bit ov, output int endt);
        int v, e, k, pt, nh, nv, o;
        v = a + 1;
        while (v % F != P/2) v++;
        e = v + 1; k = 0;
        while (1) begin
            if (e % P == 0) begin
                if (k == ty) break;
                k++;
            end
            e++;
        end
        nh = (e / P + 1) * P;
        nv = (e / F) * F + P/2;
        if (nv <= e) nv += F;
        o = (nh < nv) ? nh : nv;
        bits = '0; ov = 1'b0; endt = e;
        for (int n = 0; n < 64; n++) begin
            pt = e + 1 + xs + n * (st + 1);
            if (o < pt) begin ov = 1'b1; endt = o; break; end
            bits[n] = vid[pt] ^ inv;
            endt = pt;
            if (o == pt && n < 63) begin ov = 1'b1; break; end
        end
    endtask

    task automatic capture(input string tag, input int a, input int ty, input int xs,
                           input int st, input bit inv);
        logic [63:0] eb; bit ov; int endt;
        run_to(a - 3);
        wr(6'h04, ty); wr(6'h08, xs); wr(6'h0C, st);
        wr(6'h00, {28'd0, inv, 3'b111});
        model(a, ty, xs, st, inv, eb, ov, endt);
        run_to(endt);
        chk({tag, "_busy"}, {31'd0, user_interrupt}, 32'd0);
        chk_rd({tag, "_ctrl_pre"}, 6'h00, {28'd0, lock_exp(), 3'b001});
        tick();
        chk({tag, "_irq"}, {31'd0, user_interrupt}, 32'd1);
        chk_rd({tag, "_ctrl"}, 6'h00, {28'd0, lock_exp(), ov, 2'b10});
        chk_rd({tag, "_data0"}, 6'h18, eb[31:0]);
        chk_rd({tag, "_data1"}, 6'h1C, eb[63:32]);
    endtask

    initial begin
        logic [63:0] eb; bit ov; int endt, a, xs, st;
        for (int i = 0; i < NV; i++) vid[i] = bit'($urandom_range(1, 0));
        rst_n = 1'b0; address = '0; data_in = '0;
        data_write_n = 2'b11; data_read_n = 2'b11; ui_in = 8'b0000_0011;
        repeat (3) tick();
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) chk_rd("reset_reg", 6'(i * 4), 32'd0);
        chk("reset_irq", {31'd0, user_interrupt}, 32'd0);
        chk("uo_out", {24'd0, uo_out}, 32'd0);
        chk("data_ready", {31'd0, data_ready}, 32'd1);

        wr(6'h04, 32'hFFFF_FC05); chk_rd("target_rb", 6'h04, 32'd5);
        wr(6'h08, 32'hABCD_E064); chk_rd("xstart_rb", 6'h08, 32'd100);
        wr(6'h0C, 32'hFFFF_FF83); chk_rd("step_rb", 6'h0C, 32'd3);
        wr(6'h20, 32'hFFFF_FFFF); chk_rd("unmapped", 6'h20, 32'd0);
        wr(6'h00, 32'h6);

        gen_on = 1'b1; gt = 0;
        capture("cap1", F + P/2 - 20, 5, 100, 3, 1'b0);

        capture("cap_vinv", 2*F + P/2 - 20, 5, 100, 3, 1'b1);
        model(2*F + P/2 - 20, 5, 100, 3, 1'b1, eb, ov, endt);
        chk_rd("line_period", 6'h10, MEAS ? P : 0);
        chk_rd("frame_lines", 6'h14, MEAS ? L : 0);
        wr(6'h00, 32'h6);
        chk("irq_clear", {31'd0, user_interrupt}, 32'd0);
        chk_rd("ctrl_clear", 6'h00, {28'd0, MEAS, 3'b000});
        chk_rd("data_kept", 6'h18, eb[31:0]);

        capture("overrun", 3*F + P/2 - 20, 2, 0, 63, 1'b0);

        // ARM mid-frame: the target line of the current frame must be skipped.
        xs = $urandom_range(400, 0);
        st = $urandom_range(13, 0);
        a  = 4*F + 3*P + 10;
        run_to(a - 3);
        wr(6'h04, 5); wr(6'h08, xs); wr(6'h0C, st);
        wr(6'h00, 32'h7);
        run_to(5*F);
        chk_rd("mid_ctrl", 6'h00, {28'd0, MEAS, 3'b001});
        chk_rd("mid_data0", 6'h18, 32'd0);
        chk("mid_irq", {31'd0, user_interrupt}, 32'd0);
        model(a, 5, xs, st, 1'b0, eb, ov, endt);
        run_to(endt + 1);
        chk_rd("mid_done", 6'h00, {28'd0, MEAS, ov, 2'b10});
        chk_rd("mid_d0", 6'h18, eb[31:0]);
        chk_rd("mid_d1", 6'h1C, eb[63:32]);

        // Reset in the middle of a capture.
        a = 6*F + P/2 - 20;
        run_to(a - 3);
        wr(6'h04, 1); wr(6'h08, 5); wr(6'h0C, 1);
        wr(6'h00, 32'h7);
        run_to(6*F + 2*P + 40);
        chk_rd("samp_busy", 6'h00, {28'd0, MEAS, 3'b001});
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) chk_rd("rst_sample_reg", 6'(i * 4), 32'd0);
        chk("rst_sample_irq", {31'd0, user_interrupt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tqvp_vga_capture.md
# tqvp_vga_capture

Line-capture peripheral for TinyQV: the receiving end of the 1-bit VGA stream the VGA output peripheral generates. It watches hsync, vsync and a thresholded video bit on the input PMOD. It measures line period and frame height, then samples 64 pixels from one CPU-selected scanline into a register buffer the CPU can read. It raises an interrupt when the capture completes.

## Interface
- Parameters: none (register map and widths are fixed).
- clk  in  1  project clock (64 MHz nominal)
- rst_n  in  1  reset; synchronous, active-low; clock clk
- ui_in  in  8  PMOD in, already 2-FF synchronized; [0]=hsync, [1]=vsync, [2]=video; others unused ([7] reserved for UART RX)
- uo_out  out  8  constant 0
- address  in  6  register address
- data_in  in  32  write data; low bits used, any write size accepted
- data_write_n  in  2  11=no write
- data_read_n  in  2  11=no read
- data_out  out  32  read data for current address, combinational
- data_ready  out  1  constant 1; reads never stall
- user_interrupt  out  1  capture-done flag

## Operation
- Registers:
  - 0x00 CTRL.
    - Write: bit0 ARM, bit1 HPOL (1=hsync active-low), bit2 VPOL, bit3 VINV (invert video). Any CTRL write clears DONE, OVR and interrupt.
    - Read: {28'0, LOCK, OVR, DONE, BUSY}.
  - 0x04 TARGET_Y[9:0]; 0x08 X_START[11:0]; 0x0C STEP[6:0] (clocks per pixel minus 1); all read back as written.
  - 0x10 LINE_PERIOD[11:0], RO; 0x14 FRAME_LINES[9:0], RO.
  - 0x18 DATA0 = pixels 0..31; 0x1C DATA1 = pixels 32..63; bit i = pixel i.
  - Other addresses read 0; writes to them are ignored.
- Edge detect: hs_act = ui_in[0]^HPOL, vs_act = ui_in[1]^VPOL. A leading edge is the cycle where the active level is seen and the previous cycle's level was inactive.
- line_cnt[9:0]: cleared on a vsync leading edge; incremented on each hsync leading edge; saturates at 1023.
- FSM: IDLE -> ARMED -> WAIT_LINE -> SAMPLE -> IDLE.
  - ARM=1 write: clear DATA0/1, go to ARMED, BUSY=1. Writing ARM while BUSY restarts from ARMED.
  - ARMED: wait for a vsync leading edge -> WAIT_LINE. Captures never start mid-frame.
  - WAIT_LINE: an hsync leading edge with line_cnt==TARGET_Y (value before increment) -> SAMPLE, with x_cnt=0 on the next cycle.
  - SAMPLE: x_cnt counts clocks. Pixel 0 is sampled when x_cnt==X_START; each later pixel STEP+1 clocks after the previous. Sample value = ui_in[2]^VINV.
  - After pixel 63 is stored: DONE=1, BUSY=0, user_interrupt=1, return to IDLE.
- Overrun: an hsync or vsync leading edge during SAMPLE before pixel 63 aborts the capture. Captured bits are kept, the rest stay 0; OVR=1, DONE=1, interrupt=1.
- TARGET_Y >= lines in the frame: the FSM stays in WAIT_LINE indefinitely; software re-arms to recover.
- A write to X_START, STEP or TARGET_Y during BUSY takes effect immediately; software must not rely on this.
- Reset: all registers 0, FSM IDLE, interrupt 0, DATA cleared.

## Timing
- Edge at cycle E -> line_cnt/FSM updated at E+1; first SAMPLE cycle has x_cnt=0 at E+1.
- Pixel n is sampled at cycle E+1+X_START+n*(STEP+1); DONE and interrupt are visible at the cycle after pixel 63 is sampled.
- Input pipeline delay (2 cycles from the pin) is not compensated; software offsets X_START.
- A simultaneous CTRL write with ARM=1 and the DONE event: the write wins (DONE cleared, re-armed).
- Reads are 0-wait; data_out reflects register state as of the current cycle.

## Configuration
- VGACAP_MEASURE_EN defined:
  - Period counter (12 b, saturating at 4095) counts clocks between hsync leading edges and latches into LINE_PERIOD on each edge.
  - FRAME_LINES latches line_cnt on each vsync leading edge.
  - LOCK=1 when both latched values are nonzero, unsaturated, and the last two frames match.
- Not defined: LINE_PERIOD, FRAME_LINES and LOCK read 0; the counters are removed. Capture is unaffected.

## Test plan
- 1024x768-style stimulus (period 1344, 806 lines, HPOL=VPOL=1), two frames -> LINE_PERIOD=1344, FRAME_LINES=806, LOCK=1.
- TARGET_Y=5, X_START=100, STEP=3, video pattern = bit of (x_cnt/4) parity, ARM -> DATA0=DATA1=0xAAAAAAAA (or 0x55555555 per phase), DONE=1, interrupt=1.
- Same capture with VINV=1 -> DATA words bitwise inverted; interrupt cleared by the CTRL write.
- STEP=63, X_START=0, period 1344 -> hsync edge arrives after 21 pixels: OVR=1, DONE=1, DATA1=0, DATA0 bits 21..31=0.
- ARM mid-frame -> no capture until the next vsync leading edge; rst_n low during SAMPLE -> all registers 0, interrupt 0, BUSY=0.
- Build without VGACAP_MEASURE_EN -> 0x10/0x14 read 0, LOCK=0, and capture result identical to the second scenario.
